// File: rtl/text_pkg.sv
// Shared definitions for the text-field renderer: attribute layout, colours and character codes.
`default_nettype none

package text_pkg;

    localparam int CHAR_BITS      = 7;
    localparam int ATTR_BITS      = 7;
    localparam int COLOR_BITS     = 3;
    localparam int ATTR_FG_LSB    = 0;
    localparam int ATTR_BG_LSB    = 3;
    localparam int ATTR_BLINK_BIT = 6;

    typedef struct packed {
        logic       blink;
        logic [2:0] bg;
        logic [2:0] fg;
    } attr_t;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    localparam logic [6:0] CH_0     = 7'h30;
    localparam logic [6:0] CH_1     = 7'h31;
    localparam logic [6:0] CH_2     = 7'h32;
    localparam logic [6:0] CH_3     = 7'h33;
    localparam logic [6:0] CH_4     = 7'h34;
    localparam logic [6:0] CH_5     = 7'h35;
    localparam logic [6:0] CH_6     = 7'h36;
    localparam logic [6:0] CH_7     = 7'h37;
    localparam logic [6:0] CH_8     = 7'h38;
    localparam logic [6:0] CH_9     = 7'h39;
    localparam logic [6:0] CH_COLON = 7'h3A;
    localparam logic [6:0] CH_A     = 7'h41;
    localparam logic [6:0] CH_B     = 7'h42;
    localparam logic [6:0] CH_C     = 7'h43;
    localparam logic [6:0] CH_D     = 7'h44;
    localparam logic [6:0] CH_E     = 7'h45;
    localparam logic [6:0] CH_F     = 7'h46;
    localparam logic [6:0] CH_G     = 7'h47;
    localparam logic [6:0] CH_H     = 7'h48;
    localparam logic [6:0] CH_I     = 7'h49;
    localparam logic [6:0] CH_J     = 7'h4A;
    localparam logic [6:0] CH_K     = 7'h4B;
    localparam logic [6:0] CH_L     = 7'h4C;
    localparam logic [6:0] CH_M     = 7'h4D;
    localparam logic [6:0] CH_N     = 7'h4E;
    localparam logic [6:0] CH_O     = 7'h4F;
    localparam logic [6:0] CH_P     = 7'h50;
    localparam logic [6:0] CH_Q     = 7'h51;
    localparam logic [6:0] CH_R     = 7'h52;
    localparam logic [6:0] CH_S     = 7'h53;
    localparam logic [6:0] CH_T     = 7'h54;
    localparam logic [6:0] CH_U     = 7'h55;
    localparam logic [6:0] CH_V     = 7'h56;
    localparam logic [6:0] CH_W     = 7'h57;
    localparam logic [6:0] CH_X     = 7'h58;
    localparam logic [6:0] CH_Y     = 7'h59;
    localparam logic [6:0] CH_Z     = 7'h5A;

    function automatic attr_t unpack_attr(input logic [ATTR_BITS-1:0] raw);
        attr_t a;
        a.fg    = raw[ATTR_FG_LSB +: COLOR_BITS];
        a.bg    = raw[ATTR_BG_LSB +: COLOR_BITS];
        a.blink = raw[ATTR_BLINK_BIT];
        return a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/font_rom.sv
// Glyph ROM with a registered (1-cycle) read; rows are a fixed procedural pattern per code/line.
`default_nettype none

module font_rom #(
    parameter int CHAR_BITS = 7,
    parameter int ROW_BITS  = 6,
    parameter int WIDTH     = 32
) (
    input  logic                          clk,
    input  logic [CHAR_BITS+ROW_BITS-1:0] addr,
    output logic [WIDTH-1:0]              data
);

    function automatic logic [WIDTH-1:0] glyph_row(input logic [CHAR_BITS+ROW_BITS-1:0] a);
        logic [WIDTH-1:0] w;
        int               ch;
        int               ry;
        ch = int'(a[CHAR_BITS+ROW_BITS-1:ROW_BITS]);
        ry = int'(a[ROW_BITS-1:0]);
        for (int b = 0; b < WIDTH; b++) begin
            w[b] = (((ch * 5) + (ry * 3) + b) % 7) < 3;
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        data <= glyph_row(addr);
    end

endmodule

`default_nettype wire

// File: rtl/text_blink_gen.sv
// Free-running blink divider: toggles blink_o every BLINK_DIV clk_i cycles.
`default_nettype none

module text_blink_gen #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic blink_o
);

    localparam int               CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt     <= '0;
            blink_o <= 1'b0;
        end else if (cnt == TERMINAL) begin
            cnt     <= '0;
            blink_o <= ~blink_o;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/text_field_render.sv
// Character-cell text renderer: text RAM -> font ROM -> colour mux, 3-cycle pixel pipeline.
// Optional cursor inversion is built when macro TEXT_CURSOR_EN is defined.
`default_nettype none

module text_field_render
    import text_pkg::*;
#(
    parameter int COLS        = 20,
    parameter int ROWS        = 8,
    parameter int CHAR_W_LOG2 = 5,
    parameter int CHAR_H_LOG2 = 6,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [9:0]               pix_x,
    input  logic [9:0]               pix_y,
    input  logic                     video_on,
    input  logic                     wr_en,
    input  logic [$clog2(COLS)-1:0]  wr_col,
    input  logic [$clog2(ROWS)-1:0]  wr_row,
    input  logic [6:0]               wr_char,
    input  logic [6:0]               wr_attr,
    input  logic                     cursor_en,
    input  logic [$clog2(COLS)-1:0]  cursor_col,
    input  logic [$clog2(ROWS)-1:0]  cursor_row,
    output logic                     text_on,
    output logic [2:0]               text_rgb,
    output logic                     blink_o
);

    localparam int NUM_TILES = COLS * ROWS;
    localparam int ADDR_W    = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int ENTRY_W   = ATTR_BITS + CHAR_BITS;
    localparam int FONT_W    = 1 << CHAR_W_LOG2;

    logic [9:0]             tile_col;
    logic [9:0]             tile_row;
    logic                   in_range;
    logic [ADDR_W-1:0]      rd_addr;
    logic                   wr_ok;
    logic [ADDR_W-1:0]      wr_addr;

    logic [ENTRY_W-1:0]     text_ram [NUM_TILES];
    logic [ENTRY_W-1:0]     rd_entry;

    logic                   s0_in_range;
    logic                   s0_video;
    logic                   s0_blink;
    logic [CHAR_W_LOG2-1:0] s0_xoff;
    logic [CHAR_H_LOG2-1:0] s0_yoff;

    logic [FONT_W-1:0]      font_word;
    logic                   s1_in_range;
    logic                   s1_video;
    logic                   s1_blink;
    logic [CHAR_W_LOG2-1:0] s1_xoff;
    attr_t                  s1_attr;

    logic [2:0]             fg;
    logic [2:0]             bg;
    logic                   pixel_bit;
    logic [2:0]             rgb_next;

    assign tile_col = pix_x >> CHAR_W_LOG2;
    assign tile_row = pix_y >> CHAR_H_LOG2;
    assign in_range = (32'(tile_col) < COLS) && (32'(tile_row) < ROWS);
    assign rd_addr  = in_range ? ADDR_W'(32'(tile_row) * COLS + 32'(tile_col)) : '0;

    assign wr_ok   = wr_en && (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
    assign wr_addr = ADDR_W'(32'(wr_row) * COLS + 32'(wr_col));

    text_blink_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .blink_o (blink_o)
    );

    // Read and write share one block so a same-address read sees the pre-write entry.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            text_ram[wr_addr] <= {wr_attr, wr_char};
        end
        rd_entry <= text_ram[rd_addr];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_in_range <= 1'b0;
            s0_video    <= 1'b0;
            s0_blink    <= 1'b0;
            s0_xoff     <= '0;
            s0_yoff     <= '0;
        end else begin
            s0_in_range <= in_range;
            s0_video    <= video_on;
            s0_blink    <= blink_o;
            s0_xoff     <= pix_x[CHAR_W_LOG2-1:0];
            s0_yoff     <= pix_y[CHAR_H_LOG2-1:0];
        end
    end

    font_rom #(
        .CHAR_BITS (CHAR_BITS),
        .ROW_BITS  (CHAR_H_LOG2),
        .WIDTH     (FONT_W)
    ) u_font (
        .clk  (clk_i),
        .addr ({rd_entry[CHAR_BITS-1:0], s0_yoff}),
        .data (font_word)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_in_range <= 1'b0;
            s1_video    <= 1'b0;
            s1_blink    <= 1'b0;
            s1_xoff     <= '0;
            s1_attr     <= '0;
        end else begin
            s1_in_range <= s0_in_range;
            s1_video    <= s0_video;
            s1_blink    <= s0_blink;
            s1_xoff     <= s0_xoff;
            s1_attr     <= unpack_attr(rd_entry[ENTRY_W-1 -: ATTR_BITS]);
        end
    end

`ifdef TEXT_CURSOR_EN
    logic cursor_hit;
    logic s0_cursor;
    logic s1_cursor;

    assign cursor_hit = cursor_en && (32'(tile_col) == 32'(cursor_col))
                                  && (32'(tile_row) == 32'(cursor_row));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_cursor <= 1'b0;
            s1_cursor <= 1'b0;
        end else begin
            s0_cursor <= cursor_hit;
            s1_cursor <= s0_cursor;
        end
    end
`else
    logic unused_cursor;
    assign unused_cursor = ^{cursor_en, cursor_col, cursor_row};
`endif

    always_comb begin
        fg = s1_attr.fg;
        bg = s1_attr.bg;
`ifdef TEXT_CURSOR_EN
        if (s1_cursor && s1_blink) begin
            fg = ~s1_attr.fg;
            bg = ~s1_attr.bg;
        end
`endif
        // Blinking tiles collapse to background during the off phase.
        pixel_bit = font_word[~s1_xoff] && !(s1_attr.blink && !s1_blink);
        if (s1_in_range && s1_video) begin
            rgb_next = pixel_bit ? fg : bg;
        end else begin
            rgb_next = BLACK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            text_on  <= 1'b0;
            text_rgb <= BLACK;
        end else begin
            text_on  <= s1_in_range && s1_video;
            text_rgb <= rgb_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_text_field_render.sv
// Scoreboard bench for text_field_render (defaults geometry, BLINK_DIV=4).
`default_nettype none

module tb_text_field_render;

    localparam int TB_COLS = 20;
    localparam int TB_ROWS = 8;
`ifdef TEXT_CURSOR_EN
    localparam bit CURSOR_BUILT = 1'b1;
`else
    localparam bit CURSOR_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_on;
    logic       wr_en;
    logic [4:0] wr_col;
    logic [2:0] wr_row;
    logic [6:0] wr_char;
    logic [6:0] wr_attr;
    logic       cursor_en;
    logic [4:0] cursor_col;
    logic [2:0] cursor_row;
    logic       text_on;
    logic [2:0] text_rgb;
    logic       blink_o;

    always #5 clk = ~clk;

    text_field_render #(
        .COLS        (TB_COLS),
        .ROWS        (TB_ROWS),
        .CHAR_W_LOG2 (5),
        .CHAR_H_LOG2 (6),
        .BLINK_DIV   (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .video_on   (video_on),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_char    (wr_char),
        .wr_attr    (wr_attr),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .text_on    (text_on),
        .text_rgb   (text_rgb),
        .blink_o    (blink_o)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         edges    = 0;
    logic [13:0] ram_m [TB_COLS*TB_ROWS];
    logic [3:0] exp_q [$];
    string      tag_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic blink_model();
        return ((edges / 4) % 2) != 0;
    endfunction

    function automatic logic font_bit(input int c, input int yo, input int xo);
        int b;
        b = 31 - xo;
        return (((c * 5) + (yo * 3) + b) % 7) < 3;
    endfunction

    function automatic logic [3:0] model_pix(input int x, input int y, input logic von,
                                             input logic blink);
        int          col;
        int          row;
        logic [13:0] e;
        logic [2:0]  fg;
        logic [2:0]  bg;
        logic        bit_v;
        col = x >> 5;
        row = y >> 6;
        if (!von || col >= TB_COLS || row >= TB_ROWS) return 4'b0000;
        e     = ram_m[row * TB_COLS + col];
        fg    = e[9:7];
        bg    = e[12:10];
        bit_v = font_bit(int'(e[6:0]), y % 64, x % 32);
        if (e[13] && !blink) bit_v = 1'b0;
        if (CURSOR_BUILT && cursor_en && blink &&
            col == int'(cursor_col) && row == int'(cursor_row)) begin
            fg = ~fg;
            bg = ~bg;
        end
        return {1'b1, bit_v ? fg : bg};
    endfunction

    // Entered and left at a negedge: drive, score, then check after the next posedge.
    task automatic cycle(input string tag, input int x, input int y, input logic von,
                         input logic we, input int wc, input int wr,
                         input logic [6:0] wch, input logic [6:0] wat);
        logic [3:0] e;
        string      t;
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        video_on = von;
        wr_en    = we;
        wr_col   = 5'(wc);
        wr_row   = 3'(wr);
        wr_char  = wch;
        wr_attr  = wat;
        e = model_pix(x, y, von, blink_model());
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (we && wc < TB_COLS && wr < TB_ROWS) ram_m[wr * TB_COLS + wc] = {wat, wch};
        @(posedge clk);
        edges++;
        #1;
        t = tag_q.pop_front();
        check(t, {28'b0, text_on, text_rgb}, {28'b0, exp_q.pop_front()});
        check("blink_o", {31'b0, blink_o}, {31'b0, blink_model()});
        @(negedge clk);
    endtask

    task automatic pix(input string tag, input int x, input int y);
        cycle(tag, x, y, 1'b1, 1'b0, 0, 0, 7'h0, 7'h0);
    endtask

    task automatic write_cell(input int c, input int r, input logic [6:0] ch, input logic [6:0] at);
        cycle("wr_idle", 0, 0, 1'b0, 1'b1, c, r, ch, at);
    endtask

    task automatic restart_model();
        exp_q.delete();
        tag_q.delete();
        exp_q.push_back(4'b0000);
        tag_q.push_back("post_rst0");
        exp_q.push_back(4'b0000);
        tag_q.push_back("post_rst1");
        edges = 0;
    endtask

    initial begin
        rst_ni     = 1'b0;
        pix_x      = '0;
        pix_y      = '0;
        video_on   = 1'b0;
        wr_en      = 1'b0;
        wr_col     = '0;
        wr_row     = '0;
        wr_char    = '0;
        wr_attr    = '0;
        cursor_en  = 1'b0;
        cursor_col = '0;
        cursor_row = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_on", {31'b0, text_on}, 32'd0);
        check("rst_rgb", {29'b0, text_rgb}, 32'd0);
        check("rst_blink", {31'b0, blink_o}, 32'd0);

        @(negedge clk);
        rst_ni = 1'b1;
        restart_model();

        for (int i = 0; i < TB_COLS * TB_ROWS; i++) begin
            write_cell(i % TB_COLS, i / TB_COLS, 7'(8'h41 + (i % 26)), 7'((i * 5) % 64));
        end

        // 'H', fg=100 bg=001 at tile (0,0)
        write_cell(0, 0, 7'h48, 7'h0C);
        pix("hello_3_3", 3, 3);
        for (int k = 0; k < 32; k += 3) pix("tile00_row3", k, 3);

        pix("x640", 640, 3);
        pix("y512", 3, 512);
        pix("x639", 639, 70);
        cycle("video_off", 3, 3, 1'b0, 1'b0, 0, 0, 7'h0, 7'h0);

        write_cell(25, 0, 7'h5A, 7'h3F);
        for (int k = 0; k < 6; k++) pix("oor_write", 5 * 32 + k * 5, 64 + 10);

        write_cell(1, 0, 7'h41, 7'h4C);
        for (int k = 0; k < 20; k++) pix("blink_tile", 32 + k, 5 + k);

        write_cell(2, 1, 7'h42, 7'h1A);
        write_cell(3, 1, 7'h43, 7'h1A);
        cursor_en  = 1'b1;
        cursor_col = 5'd2;
        cursor_row = 3'd1;
        for (int k = 0; k < 12; k++) begin
            pix("cursor_tile", 64 + k * 2, 64 + k);
            pix("beside_cursor", 96 + k * 2, 64 + k);
        end
        cursor_en = 1'b0;

        write_cell(5, 2, 7'h30, 7'h2A);
        cycle("rw_old", 167, 137, 1'b1, 1'b1, 5, 2, 7'h31, 7'h15);
        pix("rw_new", 167, 137);

        for (int k = 0; k < 8 && !blink_model(); k++) pix("pre_rst", 3 + k, 3);
        pix("pre_rst_b1", 4, 4);

        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_blink", {31'b0, blink_o}, 32'd0);
        check("midrst_rgb", {29'b0, text_rgb}, 32'd0);
        check("midrst_on", {31'b0, text_on}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        restart_model();
        for (int k = 0; k < 8; k++) pix("ram_kept", k * 4, 3 + k);

        for (int k = 0; k < 3; k++) cycle("drain", 0, 0, 1'b0, 1'b0, 0, 0, 7'h0, 7'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/text_field_render.md
TEXT_FIELD_RENDER -- requirements
Module: text_field_render

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk_i and rst_ni.
REQ-002 Parameters SHALL be, one per line:
- COLS, default 20, text columns.
- ROWS, default 8, text rows.
- CHAR_W_LOG2, default 5, log2 of tile width in pixels.
- CHAR_H_LOG2, default 6, log2 of tile height in pixels.
- BLINK_DIV, default 25000000, clk_i cycles per blink half-period.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i  in  1  pixel clock.
- rst_ni  in  1  asynchronous active-low reset.
- pix_x  in  10  current pixel column.
- pix_y  in  10  current pixel row.
- video_on  in  1  visible-area flag.
- wr_en  in  1  text-RAM write strobe.
- wr_col  in  clog2(COLS)  write column.
- wr_row  in  clog2(ROWS)  write row.
- wr_char  in  7  character code.
- wr_attr  in  7  {blink, bg[2:0], fg[2:0]}.
- cursor_en  in  1  cursor display enable.
- cursor_col  in  clog2(COLS)  cursor column.
- cursor_row  in  clog2(ROWS)  cursor row.
- text_on  out  1  a tile is present at the delayed pixel.
- text_rgb  out  3  pixel colour.
- blink_o  out  1  blink phase.

Function
REQ-004 The text RAM SHALL hold COLS*ROWS entries of {attr, char}; a write SHALL take effect on the clk_i edge where wr_en=1.
REQ-005 An out-of-range write (wr_col>=COLS or wr_row>=ROWS) SHALL be ignored.
REQ-006 Tile coordinates SHALL be col=pix_x>>CHAR_W_LOG2 and row=pix_y>>CHAR_H_LOG2; a tile is in range when col<COLS and row<ROWS.
REQ-007 The pipeline SHALL have 3 stages, latency exactly 3 cycles, pixel to text_rgb/text_on:
- S0: text-RAM read, registers pixel offsets and in-range flag.
- S1: font_rom read at address {char, y_offset}.
- S2: bit select font_word[~x_offset] and colour mux.
REQ-008 Colour selection SHALL be:
- not video_on or not in range: text_on=0, text_rgb=000.
- font bit set: text_rgb=fg.
- font bit clear: text_rgb=bg.
- blink attribute set and blink_o=0: text_rgb=bg for the whole tile.
REQ-009 When the cursor is shown (blink_o=1, cursor_en=1, and tile equal to the cursor position), all fg/bg colours of that tile SHALL be inverted (bitwise NOT).
REQ-010 The blink counter SHALL count 0..BLINK_DIV-1 and free-run independently of pix_x/pix_y; at terminal count it SHALL wrap to 0 and toggle blink_o.
REQ-011 If a write and a read hit the same address in the same cycle, the read SHALL return the old data (read-before-write).
REQ-012 The stage flags (in-range, video_on, cursor-hit) SHALL travel with the data through every stage.

Reset
REQ-013 On rst_ni=0 the following SHALL clear asynchronously to 0: blink counter, blink_o, text_on, text_rgb, and all pipeline flags.
REQ-014 The text RAM contents SHALL NOT be cleared by reset.
REQ-015 The first 3 cycles after reset release SHALL output text_on=0 and text_rgb=000.

Configuration
REQ-016 With macro TEXT_CURSOR_EN defined, REQ-009 SHALL apply.
REQ-017 Without TEXT_CURSOR_EN, the cursor_* inputs SHALL be ignored and no cursor logic SHALL be synthesised.

Structure
REQ-018 Shared package text_pkg SHALL hold:
- the attribute field offsets.
- the colour constants BLACK..WHITE.
- the character-code constants for the digits 0x30 to 0x39, ':' (0x3A), and 'A' to 'Z'.
REQ-019 The blink divider SHALL be the sub-module text_blink_gen; font_rom SHALL be instantiated unchanged, with a 1-cycle read.

Verification
REQ-020 Write char 0x48, attr 0x0C (fg=100, bg=001) at (0,0), then scan pixel (3,3) -> after 3 cycles, text_rgb equals the font_rom pixel colour and text_on=1.
REQ-021 Pixel at col=COLS (x=640 with defaults) -> text_on=0 and text_rgb=000.
REQ-022 BLINK_DIV=4 and attr blink=1 -> blink_o toggles every 4 cycles, and the tile shows bg only while blink_o=0.
REQ-023 TEXT_CURSOR_EN defined, cursor at (2,1), blink_o=1 -> tile (2,1) colours are inverted; tile (3,1) is unchanged.
REQ-024 Assert rst_ni mid-frame with blink_o=1 -> blink_o=0 and text_rgb=000 immediately, and the RAM character is still read back after release.
REQ-025 Write and read the same address in the same cycle -> the old character is rendered, and the new one from the next scan.
